// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-N valid/ready demux with per-channel holding slots and optional packet lock
module stream_demux_n #(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int PKT_MODE = 1,
   parameter int SELW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_data,
   input  logic [SELW-1:0] in_sel,
   input  logic            in_last,
   output logic [N-1:0]    out_valid,
   input  logic [N-1:0]    out_ready,
   output logic [N*W-1:0]  out_data,
   output logic [N-1:0]    out_last,
   output logic            busy,
   output logic [15:0]     drop_count
);
   typedef enum logic {IDLE, LOCK} state_t;
   state_t state, state_nx;
   logic [SELW-1:0] lock_sel, t;
   logic t_ok, acc;
   assign t        = (state == LOCK) ? lock_sel : in_sel;
   assign t_ok     = int'(t) < N;
   assign in_ready = t_ok ? (!out_valid[t] || out_ready[t]) : 1'b1;
   assign acc      = in_valid && in_ready;
   assign busy     = state == LOCK;
   always_comb begin
      state_nx = state;
      if (PKT_MODE != 0 && acc) state_nx = in_last ? IDLE : LOCK;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= '0;
         out_data   <= '0;
         out_last   <= '0;
         drop_count <= '0;
         state      <= IDLE;
         lock_sel   <= '0;
      end else begin
         // a load wins over a drain so a draining slot refills without a bubble
         for (int k = 0; k < N; k++) begin
            if (acc && t_ok && int'(t) == k) begin
               out_valid[k]       <= 1'b1;
               out_data[k*W +: W] <= in_data;
               out_last[k]        <= in_last;
            end else if (out_ready[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
         if (acc && !t_ok && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         state <= state_nx;
         if (state == IDLE && acc) lock_sel <= in_sel;
      end
   end
endmodule

// File: tb/tb_stream_demux_n.sv
// tb_stream_demux_n: three demux configurations on shared random/directed stimulus, checked against a slot-level model
module tb_stream_demux_n;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic       in_valid = 1'b0, in_last = 1'b0;
   logic [7:0] in_data = '0;
   logic [1:0] in_sel = '0;
   logic [3:0] out_ready = '0;
   logic rdy0, rdy1, rdy2, bz0, bz1, bz2;
   logic [3:0] ov0, ol0, ov2, ol2;
   logic [2:0] ov1, ol1;
   logic [31:0] od0, od2;
   logic [23:0] od1;
   logic [15:0] dc0, dc1, dc2;
   stream_demux_n #(.N(4), .W(8), .PKT_MODE(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
      .in_sel(in_sel), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
      .out_data(od0), .out_last(ol0), .busy(bz0), .drop_count(dc0));
   stream_demux_n #(.N(3), .W(8), .PKT_MODE(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
      .in_sel(in_sel), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready[2:0]),
      .out_data(od1), .out_last(ol1), .busy(bz1), .drop_count(dc1));
   stream_demux_n #(.N(4), .W(8), .PKT_MODE(0)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
      .in_sel(in_sel), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
      .out_data(od2), .out_last(ol2), .busy(bz2), .drop_count(dc2));
   localparam int CN[3] = '{4, 3, 4};
   localparam bit CP[3] = '{1'b1, 1'b1, 1'b0};
   int vectors = 0, miscompares = 0;
   // model: per config, the contents of each channel's slot plus the packet lock and drop tally
   bit         mv[3][4];
   logic [7:0] md[3][4];
   bit         ml[3][4];
   bit         mlk[3];
   int         mt[3];
   int         mdr[3];
   task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d got=%0h expected=%0h", tag, d, got, exp);
      end
   endtask
   function automatic int tgt(int d);
      return (CP[d] && mlk[d]) ? mt[d] : int'(in_sel);
   endfunction
   function automatic bit mready(int d);
      int t = tgt(d);
      return t >= CN[d] || !mv[d][t] || out_ready[t];
   endfunction
   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 4; k++) begin
            mv[d][k] = 0;
            md[d][k] = '0;
            ml[d][k] = 0;
         end
         mlk[d] = 0;
         mt[d]  = 0;
         mdr[d] = 0;
      end
   endtask
   task automatic model_step();
      if (rst) begin
         model_reset();
         return;
      end
      for (int d = 0; d < 3; d++) begin
         int t = tgt(d);
         bit acc = in_valid && mready(d);
         for (int k = 0; k < CN[d]; k++) begin
            if (mv[d][k] && out_ready[k]) mv[d][k] = 0;
            if (acc && t == k) begin
               mv[d][k] = 1;
               md[d][k] = in_data;
               ml[d][k] = in_last;
            end
         end
         if (acc && t >= CN[d]) mdr[d] = (mdr[d] == 65535) ? 65535 : mdr[d] + 1;
         if (CP[d] && acc) begin
            mlk[d] = !in_last;
            mt[d]  = t;
         end
      end
   endtask
   task automatic check_outs();
      for (int d = 0; d < 3; d++) begin
         logic [31:0] eov = '0, eol = '0, eod = '0;
         for (int k = 0; k < CN[d]; k++) begin
            eov[k]         = mv[d][k];
            eol[k]         = ml[d][k];
            eod[k*8 +: 8]  = md[d][k];
         end
         chk("out_valid", d, d == 0 ? 32'(ov0) : d == 1 ? 32'(ov1) : 32'(ov2), eov);
         chk("out_data", d, d == 0 ? od0 : d == 1 ? 32'(od1) : od2, eod);
         chk("out_last", d, d == 0 ? 32'(ol0) : d == 1 ? 32'(ol1) : 32'(ol2), eol);
         chk("busy", d, d == 0 ? 32'(bz0) : d == 1 ? 32'(bz1) : 32'(bz2), 32'(CP[d] && mlk[d]));
         chk("drop_count", d, d == 0 ? 32'(dc0) : d == 1 ? 32'(dc1) : 32'(dc2), mdr[d]);
      end
   endtask
   task automatic check_ready();
      for (int d = 0; d < 3; d++)
         chk("in_ready", d, d == 0 ? 32'(rdy0) : d == 1 ? 32'(rdy1) : 32'(rdy2), 32'(mready(d)));
   endtask
   task automatic cyc(input logic v, input logic [1:0] s, input logic [7:0] dat, input logic l,
                      input logic [3:0] ordy, input logic r);
      @(negedge clk);
      check_outs();
      in_valid  = v;
      in_sel    = s;
      in_data   = dat;
      in_last   = l;
      out_ready = ordy;
      rst       = r;
      #1;
      check_ready();
      model_step();
   endtask
   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      for (int i = 0; i < 4; i++) cyc(1, 2'(i), 8'hA0 + 8'(i), 1, 4'hF, 0);
      repeat (2) cyc(0, 0, 0, 0, 4'hF, 0);
      cyc(1, 2, 8'h11, 1, 4'b1011, 0);
      cyc(1, 1, 8'h44, 1, 4'b1011, 0);
      repeat (2) cyc(1, 2, 8'h22, 1, 4'b1011, 0);
      chk("hold_data", 0, 32'(od0[23:16]), 32'h11);
      chk("hold_ready", 0, 32'(rdy0), 0);
      cyc(1, 2, 8'h22, 1, 4'hF, 0);
      repeat (2) cyc(0, 0, 0, 0, 4'hF, 0);
      cyc(1, 3, 8'h01, 0, 4'hF, 0);
      cyc(1, 0, 8'h02, 0, 4'hF, 0);
      cyc(1, 0, 8'h03, 1, 4'hF, 0);
      repeat (2) cyc(0, 0, 0, 0, 4'hF, 0);
      for (int i = 0; i < 10; i++) cyc(1, 1, 8'(i), i == 9, 4'hF, 0);
      repeat (2) cyc(0, 0, 0, 0, 4'hF, 0);
      cyc(1, 2, 8'h05, 0, 4'b1011, 0);
      cyc(1, 2, 8'h06, 0, 4'b1011, 0);
      cyc(0, 0, 0, 0, 4'b1011, 1);
      cyc(1, 1, 8'h07, 1, 4'hF, 0);
      repeat (2) cyc(0, 0, 0, 0, 4'hF, 0);
      repeat (2000)
         cyc(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom),
             ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF, $urandom_range(0, 99) == 0);
      cyc(0, 0, 0, 0, 4'hF, 1);
      cyc(1, 3, 8'h55, 1, 4'hF, 0);
      for (int i = 0; i < 4; i++) cyc(1, 3, 8'(i), i == 3, 4'hF, 0);
      cyc(0, 0, 0, 0, 4'hF, 0);
      chk("drop_five", 1, 32'(dc1), 5);
      repeat (65529) cyc(1, 3, 8'h00, 1, 4'hF, 0);
      cyc(0, 0, 0, 0, 4'hF, 0);
      chk("drop_fffe", 1, 32'(dc1), 32'hFFFE);
      repeat (3) cyc(1, 3, 8'h00, 1, 4'hF, 0);
      cyc(0, 0, 0, 0, 4'hF, 0);
      chk("drop_sat", 1, 32'(dc1), 32'hFFFF);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
